// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared float field widths, constants and accumulator sequencer state encodings
package fp_pkg;

   localparam int FP_W  = 32;
   localparam int EXP_W = 8;
   localparam int MAN_W = 23;

   localparam logic [FP_W-1:0] FP_POS_ZERO = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT_IN  = 2'd1,
      ST_WAIT_ADD = 2'd2,
      ST_DONE     = 2'd3
   } acc_state_t;

endpackage

// File: rtl/fp_accum_seq.sv
// rtl/fp_accum_seq.sv - reduces a stream of LEN floats to one sum through an external shared adder
module fp_accum_seq
   import fp_pkg::*;
#(
   parameter int ADD_LAT = 2,
   parameter int CNT_W   = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CNT_W-1:0] len,
   input  logic             in_valid,
   input  logic [FP_W-1:0]  in_data,
   output logic             in_ready,
   output logic [FP_W-1:0]  add_a,
   output logic [FP_W-1:0]  add_b,
   output logic             add_go,
   input  logic [FP_W-1:0]  add_result,
   output logic             out_valid,
   output logic [FP_W-1:0]  out_data,
   input  logic             out_ready,
   output logic             busy
);

   // Timer must hold the value ADD_LAT itself.
   localparam int TMR_W = (ADD_LAT < 2) ? 1 : $clog2(ADD_LAT + 1);

   acc_state_t       r_state;
   acc_state_t       w_next;
   logic [FP_W-1:0]  r_acc;
   logic [FP_W-1:0]  r_add_a;
   logic [FP_W-1:0]  r_add_b;
   logic             r_add_go;
   logic [FP_W-1:0]  r_out_data;
   logic [CNT_W-1:0] r_count;
   logic [TMR_W-1:0] r_timer;
   logic             r_first;

   logic             w_xfer;
   logic             w_expire;
   logic             w_last;

   // An element is consumed only while waiting for input; the adder result is
   // trusted only on the edge where the latency timer runs out.
   assign w_xfer   = (r_state == ST_WAIT_IN) && in_valid;
   assign w_expire = (r_state == ST_WAIT_ADD) && (r_timer == TMR_W'(1));
   assign w_last   = (r_count == CNT_W'(1));

   // State register; reset abandons any reduction in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state decode.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_next = (len == '0) ? ST_DONE : ST_WAIT_IN;
            end
         end
         ST_WAIT_IN: begin
            if (w_xfer) begin
               if (r_first) begin
                  w_next = w_last ? ST_DONE : ST_WAIT_IN;
               end else begin
                  w_next = ST_WAIT_ADD;
               end
            end
         end
         ST_WAIT_ADD: begin
            if (w_expire) begin
               w_next = w_last ? ST_DONE : ST_WAIT_IN;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               w_next = ST_IDLE;
            end
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // State-decoded handshake and status outputs.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      case (r_state)
         ST_IDLE:    busy      = 1'b0;
         ST_WAIT_IN: in_ready  = 1'b1;
         ST_DONE:    out_valid = 1'b1;
         default:    busy      = 1'b1;
      endcase
   end

   // Datapath: accumulator, operand registers, element count and latency timer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc      <= FP_POS_ZERO;
         r_add_a    <= FP_POS_ZERO;
         r_add_b    <= FP_POS_ZERO;
         r_add_go   <= 1'b0;
         r_out_data <= FP_POS_ZERO;
         r_count    <= '0;
         r_timer    <= '0;
         r_first    <= 1'b0;
      end else begin
         r_add_go <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_count <= len;
                  r_first <= 1'b1;
                  if (len == '0) begin
                     r_out_data <= FP_POS_ZERO;
                  end
               end
            end
            ST_WAIT_IN: begin
               if (w_xfer) begin
                  if (r_first) begin
                     // First element bypasses the adder so -0.0 and denormals survive.
                     r_acc   <= in_data;
                     r_first <= 1'b0;
                     r_count <= r_count - CNT_W'(1);
                     if (w_last) begin
                        r_out_data <= in_data;
                     end
                  end else begin
                     r_add_a  <= r_acc;
                     r_add_b  <= in_data;
                     r_add_go <= 1'b1;
                     r_timer  <= TMR_W'(ADD_LAT);
                  end
               end
            end
            ST_WAIT_ADD: begin
               r_timer <= r_timer - TMR_W'(1);
               if (w_expire) begin
                  r_acc   <= add_result;
                  r_count <= r_count - CNT_W'(1);
                  if (w_last) begin
                     r_out_data <= add_result;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign add_a    = r_add_a;
   assign add_b    = r_add_b;
   assign add_go   = r_add_go;
   assign out_data = r_out_data;

endmodule

// File: tb/tb_fp_accum_seq.sv
// tb/tb_fp_accum_seq.sv - directed table-driven bench for fp_accum_seq with a lookup-table adder model
module tb_fp_accum_seq;

   localparam int ADD_LAT = 2;
   localparam int CNT_W   = 10;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic [CNT_W-1:0] len;
   logic             in_valid;
   logic [31:0]      in_data;
   logic             in_ready;
   logic [31:0]      add_a;
   logic [31:0]      add_b;
   logic             add_go;
   logic [31:0]      add_result;
   logic             out_valid;
   logic [31:0]      out_data;
   logic             out_ready;
   logic             busy;

   int n_tests;
   int n_fail;
   int go_cnt;
   int bad_ir;
   int ir_rem;

   fp_accum_seq #(.ADD_LAT(ADD_LAT), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .len        (len),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .add_a      (add_a),
      .add_b      (add_b),
      .add_go     (add_go),
      .add_result (add_result),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_ready  (out_ready),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hand-computed sums for the operand pairs this bench produces.
   function automatic logic [31:0] add_fn(input logic [31:0] a, input logic [31:0] b);
      case ({a, b})
         {32'h40E80000, 32'h3EC00000}: return 32'h40F40000;
         {32'h3F800000, 32'h40000000}: return 32'h40400000;
         {32'h40400000, 32'h40400000}: return 32'h40C00000;
         {32'h40C00000, 32'h40800000}: return 32'h41200000;
         {32'h40C00000, 32'h40E00000}: return 32'h41500000;
         {32'h42820000, 32'hC27C0000}: return 32'h40000000;
         default:                      return 32'hDEADBEEF;
      endcase
   endfunction

   // Adder model: operand registers count as the first latency edge, one more stage here.
   logic [31:0] r_add_pipe;
   always @(posedge clk) r_add_pipe <= add_fn(add_a, add_b);
   assign add_result = r_add_pipe;

   // Monitor: count add_go pulses and flag in_ready during the adder wait window.
   always @(negedge clk) begin
      if (!rst_n) begin
         ir_rem = 0;
      end else begin
         if (add_go) begin
            go_cnt = go_cnt + 1;
            ir_rem = ADD_LAT;
         end
         if (ir_rem > 0) begin
            if (in_ready) bad_ir = bad_ir + 1;
            ir_rem = ir_rem - 1;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      int          n;
      logic [31:0] e0, e1, e2, e3;
      int          gap;
      int          hold;
      bit          poke;
      logic [31:0] sum;
      int          go;
      int          lat;
   } vec_t;

   vec_t vecs[6];

   function automatic vec_t mk(input int n, input logic [31:0] e0, input logic [31:0] e1,
                               input logic [31:0] e2, input logic [31:0] e3, input int gap,
                               input int hold, input bit poke, input logic [31:0] sum,
                               input int go, input int lat);
      vec_t v;
      v.n = n; v.e0 = e0; v.e1 = e1; v.e2 = e2; v.e3 = e3;
      v.gap = gap; v.hold = hold; v.poke = poke;
      v.sum = sum; v.go = go; v.lat = lat;
      return v;
   endfunction

   function automatic logic [31:0] elem(input vec_t v, input int i);
      case (i)
         0:       return v.e0;
         1:       return v.e1;
         2:       return v.e2;
         default: return v.e3;
      endcase
   endfunction

   task automatic do_run(input vec_t v, input string tag);
      int          idx;
      int          gapc;
      int          lat;
      int          go_base;
      bit          xfer;
      bit          stable;
      logic [31:0] sum;

      go_base = go_cnt;
      idx     = 0;
      gapc    = v.gap;
      lat     = -1;
      sum     = 32'hxxxxxxxx;
      start   = 1'b1;
      len     = CNT_W'(v.n);
      in_valid = 1'b0;
      for (int cyc = 1; cyc <= 300; cyc++) begin
         xfer = in_valid && in_ready;
         @(posedge clk);
         #1;
         start = 1'b0;
         if (xfer) begin
            idx++;
            gapc = v.gap;
         end
         if (out_valid) begin
            lat = cyc;
            sum = out_data;
            break;
         end
         if (v.poke && cyc == 2) begin
            start = 1'b1;
            len   = '0;
         end
         if (idx < v.n && gapc == 0) begin
            in_valid = 1'b1;
            in_data  = elem(v, idx);
         end else begin
            in_valid = 1'b0;
            in_data  = 32'h7FC00000;
            if (gapc > 0 && in_ready) gapc--;
         end
      end
      in_valid = 1'b0;
      start    = 1'b0;

      check({tag, " done_seen"}, 32'(lat > 0), 32'd1);
      check({tag, " out_data"}, sum, v.sum);
      check({tag, " add_go_count"}, 32'(go_cnt - go_base), 32'(v.go));
      if (v.lat >= 0) check({tag, " latency"}, 32'(lat), 32'(v.lat));

      if (lat > 0) begin
         stable = 1'b1;
         for (int h = 0; h < v.hold; h++) begin
            start = v.poke && (h == 2);
            len   = '0;
            @(posedge clk);
            #1;
            start = 1'b0;
            if (!out_valid || out_data !== sum) stable = 1'b0;
         end
         if (v.hold > 0) check({tag, " held_stable"}, 32'(stable), 32'd1);
         out_ready = 1'b1;
         start     = v.poke;
         len       = CNT_W'(1);
         @(posedge clk);
         #1;
         out_ready = 1'b0;
         start     = 1'b0;
         check({tag, " out_valid_after_take"}, 32'(out_valid), 32'd0);
         check({tag, " busy_after_take"}, 32'(busy), 32'd0);
      end
   endtask

   initial begin
      n_tests   = 0;
      n_fail    = 0;
      go_cnt    = 0;
      bad_ir    = 0;
      ir_rem    = 0;
      rst_n     = 1'b0;
      start     = 1'b0;
      len       = '0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;

      vecs[0] = mk(2, 32'h40E80000, 32'h3EC00000, 32'h0, 32'h0, 0, 0, 1'b0, 32'h40F40000, 1, 5);
      vecs[1] = mk(4, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 0, 0, 1'b0,
                   32'h41200000, 3, 2 + 3 * (ADD_LAT + 1));
      vecs[2] = mk(1, 32'hC0E00000, 32'h0, 32'h0, 32'h0, 0, 0, 1'b0, 32'hC0E00000, 0, 2);
      vecs[3] = mk(0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 1'b0, 32'h00000000, 0, 1);
      vecs[4] = mk(2, 32'h40C00000, 32'h40E00000, 32'h0, 32'h0, 3, 5, 1'b1, 32'h41500000, 1, -1);
      vecs[5] = mk(2, 32'h42820000, 32'hC27C0000, 32'h0, 32'h0, 0, 0, 1'b0, 32'h40000000, 1, 5);

      #1;
      check("rst in_ready", 32'(in_ready), 32'd0);
      check("rst add_go", 32'(add_go), 32'd0);
      check("rst out_valid", 32'(out_valid), 32'd0);
      check("rst busy", 32'(busy), 32'd0);
      check("rst add_a", add_a, 32'h0);
      check("rst add_b", add_b, 32'h0);
      check("rst out_data", out_data, 32'h0);

      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 5; i++) begin
         do_run(vecs[i], $sformatf("vec%0d", i));
      end
      check("in_ready_low_in_wait_add", 32'(bad_ir), 32'd0);

      // Abort a LEN=3 run while the adder is busy.
      start    = 1'b1;
      len      = CNT_W'(3);
      in_valid = 1'b1;
      in_data  = 32'h3F800000;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #1;
      in_data = 32'h40000000;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("abort in_wait_add", 32'({busy, in_ready, add_go}), 32'b101);
      rst_n = 1'b0;
      #1;
      check("abort busy", 32'(busy), 32'd0);
      check("abort add_go", 32'(add_go), 32'd0);
      check("abort out_valid", 32'(out_valid), 32'd0);
      check("abort in_ready", 32'(in_ready), 32'd0);
      check("abort add_a", add_a, 32'h0);
      check("abort add_b", add_b, 32'h0);
      check("abort out_data", out_data, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("abort no_result", 32'(out_valid), 32'd0);

      do_run(vecs[5], "vec5");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fp_accum_seq.md
Name: fp_accum_seq

Overview:
- Sequencer that reduces a stream of LEN single-precision floats to one sum using a single shared, clocked floating-point adder (fp_add_2).
- Used in the CNN datapath to accumulate convolution products or partial sums.
- Owns the accumulator register, the element count and the adder-latency timer. Drives the adder operands and captures the adder result.
- The adder is instantiated beside this block at the integration level, not inside it.

Parameters:
- ADD_LAT, 2: rising edges from operand load to valid adder result; must be >= 1.
- CNT_W, 10: width of the element-count field.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a reduction; honoured only in IDLE.
- len  in  CNT_W  element count, sampled with start.
- in_valid  in  1  input element valid.
- in_data  in  32  IEEE-754 single-precision element.
- in_ready  out  1  block accepts in_data this cycle.
- add_a  out  32  adder operand A (registered).
- add_b  out  32  adder operand B (registered).
- add_go  out  1  one-cycle pulse marking the edge new operands were loaded.
- add_result  in  32  adder output, concatenated as {sign, exponent[7:0], mantissa[22:0]}.
- out_valid  out  1  sum available; held until taken.
- out_data  out  32  final sum.
- out_ready  in  1  consumer accepts out_data.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE.
  - in_ready, add_go, out_valid and busy are 0.
  - add_a, add_b, out_data and the accumulator are 32'h0000_0000 (+0.0).
  - Count and timer are 0.
  - Reset mid-operation abandons the reduction; no partial result is emitted.
- States: IDLE, WAIT_IN, WAIT_ADD, DONE.
- IDLE:
  - start=1 with len=0: out_data=+0.0 and go to DONE.
  - start=1 with len>0: load count=len, set first-element flag and go to WAIT_IN.
  - start is ignored in every other state.
- WAIT_IN:
  - in_ready=1 combinationally in this state only. A transfer occurs when in_valid and in_ready are both high.
  - First element: acc <= in_data with no adder use, so -0.0 and denormals pass unaltered; count decrements.
  - Later elements: add_a <= acc, add_b <= in_data, add_go pulses for one cycle, timer <= ADD_LAT, and go to WAIT_ADD.
  - If the decremented count is 0 after the first element: out_data <= acc source and go to DONE.
- WAIT_ADD:
  - in_ready=0; timer decrements each edge.
  - On the edge where the timer reaches 0: acc <= add_result and count decrements.
  - If the count is now 0: out_data <= add_result and go to DONE. Otherwise go to WAIT_IN.
  - Throughput: one element per ADD_LAT+1 cycles after the first.
- DONE:
  - out_valid=1 and out_data stable.
  - When out_valid and out_ready are both high: out_valid falls next edge and go to IDLE.
  - A start in the same cycle as that handshake is ignored.
- Latency for LEN=N>1 with in_valid always high: start edge to out_valid = 1 + 1 + (N-1)(ADD_LAT+1) cycles.
- add_a and add_b hold their values between loads. The adder is free-running, so add_result is sampled only at timer expiry.
- No arithmetic is done in this block. NaN and Inf pass through the adder untouched.

Decomposition:
- Shared package fp_pkg holds:
  - FP_W=32, EXP_W=8, MAN_W=23, FP_POS_ZERO=32'h0.
  - State encodings IDLE/WAIT_IN/WAIT_ADD/DONE.
- No sub-module inside this block.
- The integration wrapper fp_accum_unit instantiates fp_accum_seq and fp_add_2. It wires add_a/add_b to A_FP/B_FP and {sign, exponent, mantissa} to add_result.

Test Plan:
- LEN=2, elements 0x40E80000 (7.25) then 0x3EC00000 (0.375) -> out_data=0x40F40000 (7.625); one add_go pulse.
- LEN=4, elements 1.0, 2.0, 3.0, 4.0 (0x3F800000, 0x40000000, 0x40400000, 0x40800000) with in_valid always high -> out_data=0x41200000 (10.0); out_valid exactly 2+3*(ADD_LAT+1) cycles after start; in_ready low during every WAIT_ADD.
- LEN=1, element 0xC0E00000 (-7.0) -> out_data=0xC0E00000; add_go never pulses. Then LEN=0 -> out_data=0x00000000 one cycle after start.
- LEN=2, elements 0x40C00000 (6.0) then 0x40E00000 (7.0), in_valid gapped by 3 idle cycles and out_ready held low 5 cycles -> out_data=0x41500000 (13.0) stable with out_valid high until out_ready; start pulsed while busy is ignored.
- LEN=3 run with rst_n asserted during WAIT_ADD -> all outputs immediately at reset values. Then a new LEN=2 run, 0x42820000 (65.0) + 0xC27C0000 (-63.0) -> out_data=0x40000000 (2.0).
